// File: rtl/spi_slave_pkg.sv
// Shared defaults for the SPI slave and its pin synchronizer.
package spi_slave_pkg;
  localparam int unsigned DATA_W_DEF      = 8;
  localparam int unsigned SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for an asynchronous pin, with rise/fall pulses
// derived from the synchronized level.
module spi_edge_sync
  import spi_slave_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave, MSB first, active-high select. Pins are oversampled in
// the clk domain; the host decoder sees byte progress as clk-domain pulses.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              css,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] feed_data,
  output logic [DATA_W-1:0] dat_i,
  output logic [DATA_W-1:0] ndat_i,
  output logic              sck_posedge,
  output logic              accep_dat_o,
  output logic              spi_rdy,
  output logic              spi_prerdy
);

  localparam int unsigned       CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

  logic sck_rise, sck_fall, unused_sck_s;
  logic css_s, css_rise, unused_css_fall;
  logic mosi_s, unused_mosi_rise, unused_mosi_fall;
  logic sck_negedge, load;

  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, tx_idx;
  logic              miso_q, miso_d;
  logic              rdy_q, rdy_d;

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .pin_i(sck),
    .sync_o(unused_sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_css (
    .clk(clk), .rst_n(rst_n), .pin_i(css),
    .sync_o(css_s), .rise_o(css_rise), .fall_o(unused_css_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .pin_i(mosi),
    .sync_o(mosi_s), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
  );

  assign sck_posedge = sck_rise & css_s;
  assign sck_negedge = sck_fall & css_s;
  assign ndat_i      = {rx_q[DATA_W-2:0], mosi_s};
  assign spi_prerdy  = (cnt_q == LAST);
  assign tx_idx      = LAST - cnt_q;
  // Reload on select and in the spi_rdy cycle, giving the parent one cycle to refresh feed_data.
  assign load        = css_rise | (rdy_q & css_s);

  always_comb begin
    rx_d   = rx_q;
    cnt_d  = cnt_q;
    dat_d  = dat_q;
    tx_d   = tx_q;
    miso_d = miso_q;
    rdy_d  = sck_posedge & spi_prerdy;
    if (!css_s) begin
      rx_d  = '0;
      cnt_d = '0;
    end else if (sck_posedge) begin
      rx_d  = ndat_i;
      cnt_d = spi_prerdy ? '0 : cnt_q + 1'b1;
      if (spi_prerdy) dat_d = ndat_i;
    end
    if (load) begin
      tx_d   = feed_data;
      miso_d = feed_data[DATA_W-1];
    end else if (sck_negedge) begin
      miso_d = tx_q[tx_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q   <= '0;
      cnt_q  <= '0;
      dat_q  <= '0;
      tx_q   <= '1;
      miso_q <= 1'b1;
      rdy_q  <= 1'b0;
    end else begin
      rx_q   <= rx_d;
      cnt_q  <= cnt_d;
      dat_q  <= dat_d;
      tx_q   <= tx_d;
      miso_q <= miso_d;
      rdy_q  <= rdy_d;
    end
  end

  assign dat_i       = dat_q;
  assign miso        = miso_q;
  assign spi_rdy     = rdy_q;
  assign accep_dat_o = load;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: acts as a mode-0 SPI master and checks the
// clk-domain pulses, received bytes and miso stream.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       css = 1'b0;
  logic       mosi = 1'b0;
  logic [7:0] feed_data = 8'hFF;
  logic       miso;
  logic [7:0] dat_i, ndat_i;
  logic       sck_posedge, accep_dat_o, spi_rdy, spi_prerdy;

  spi_slave dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .css(css), .mosi(mosi),
    .miso(miso), .feed_data(feed_data), .dat_i(dat_i), .ndat_i(ndat_i),
    .sck_posedge(sck_posedge), .accep_dat_o(accep_dat_o),
    .spi_rdy(spi_rdy), .spi_prerdy(spi_prerdy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int n_pos = 0, n_pre = 0, n_rdy = 0, n_acc = 0, pre_err = 0, pos = 0;
  logic [7:0] last_ndat = 8'h00;
  logic [7:0] last_dat = 8'h00;

  always @(negedge clk) begin
    if (sck_posedge) begin
      n_pos++;
      if (spi_prerdy !== (pos == 7)) pre_err++;
      if (spi_prerdy) begin
        n_pre++;
        last_ndat = ndat_i;
      end
      pos = (pos + 1) % 8;
    end
    if (!rst_n || !css) pos = 0;
    if (spi_rdy) begin
      n_rdy++;
      last_dat = dat_i;
    end
    if (accep_dat_o) n_acc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] mo, input int half, input logic [7:0] nxt,
                      output logic [7:0] mi);
    for (int i = 7; i >= 0; i--) begin
      mosi = mo[i];
      repeat (half) @(negedge clk);
      mi[i] = miso;
      sck = 1'b1;
      for (int c = 0; c < half; c++) begin
        @(negedge clk);
        if (spi_rdy) feed_data = nxt;
      end
      sck = 1'b0;
    end
    repeat (half) @(negedge clk);
  endtask

  task automatic partial(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi = 1'b1;
      repeat (8) @(negedge clk);
      sck = 1'b1;
      repeat (8) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] mi;
    logic [7:0] b2b_rx [3];
    logic [7:0] b2b_fd [3];
    logic [7:0] b2b_mi [3];
    int s_pos, s_pre, s_rdy, s_acc, s_acc0;

    b2b_rx = '{8'h11, 8'h22, 8'h33};
    b2b_fd = '{8'hC3, 8'h0F, 8'hE7};
    b2b_mi = '{8'h5A, 8'hC3, 8'h0F};

    repeat (3) @(negedge clk);
    check("rst_dat", dat_i, 8'h00);
    check("rst_miso", miso, 1'b1);
    check("rst_rdy", spi_rdy, 1'b0);
    check("rst_accep", accep_dat_o, 1'b0);
    check("rst_posedge", sck_posedge, 1'b0);
    check("rst_prerdy", spi_prerdy, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    feed_data = 8'h81;
    s_acc0 = n_acc;
    css = 1'b1;
    repeat (6) @(negedge clk);
    check("sel_accep", n_acc - s_acc0, 1);
    check("sel_miso", miso, 1'b1);

    s_pos = n_pos; s_pre = n_pre; s_rdy = n_rdy;
    xfer(8'h3C, 8, 8'h5A, mi);
    check("rx_pos_cnt", n_pos - s_pos, 8);
    check("rx_pre_cnt", n_pre - s_pre, 1);
    check("rx_ndat", last_ndat, 8'h3C);
    check("rx_rdy_cnt", n_rdy - s_rdy, 1);
    check("rx_rdy_dat", last_dat, 8'h3C);
    check("rx_dat", dat_i, 8'h3C);
    check("tx_81", mi, 8'h81);
    check("tx_accep", n_acc - s_acc0, 2);

    for (int b = 0; b < 3; b++) begin
      s_rdy = n_rdy;
      xfer(b2b_rx[b], 8, b2b_fd[b], mi);
      check("b2b_rdy_cnt", n_rdy - s_rdy, 1);
      check("b2b_dat", last_dat, b2b_rx[b]);
      check("b2b_miso", mi, b2b_mi[b]);
    end
    check("b2b_accep", n_acc - s_acc0, 5);
    check("prerdy_pos", pre_err, 0);

    s_rdy = n_rdy;
    partial(5);
    repeat (8) @(negedge clk);
    css = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_rdy", n_rdy - s_rdy, 0);
    check("abort_dat", dat_i, 8'h33);
    check("abort_miso", miso, 1'b1);

    s_pos = n_pos;
    for (int i = 0; i < 4; i++) begin
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
      repeat (4) @(negedge clk);
    end
    check("desel_pos", n_pos - s_pos, 0);
    check("desel_dat", dat_i, 8'h33);

    feed_data = 8'h6B;
    s_acc = n_acc;
    css = 1'b1;
    repeat (6) @(negedge clk);
    check("resel_miso", miso, 1'b0);
    check("resel_accep", n_acc - s_acc, 1);
    s_rdy = n_rdy;
    xfer(8'hF0, 8, 8'h3A, mi);
    check("resel_rdy_cnt", n_rdy - s_rdy, 1);
    check("resel_dat", dat_i, 8'hF0);
    check("resel_tx", mi, 8'h6B);

    xfer(8'h55, 4, 8'h00, mi);
    check("fast_dat", dat_i, 8'h55);
    check("fast_tx", mi, 8'h3A);
    check("prerdy_pos2", pre_err, 0);

    partial(3);
    check("pre_rst_miso", miso, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dat", dat_i, 8'h00);
    check("arst_miso", miso, 1'b1);
    check("arst_rdy", spi_rdy, 1'b0);
    check("arst_accep", accep_dat_o, 1'b0);
    check("arst_posedge", sck_posedge, 1'b0);
    sck = 1'b0; css = 1'b0; mosi = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    feed_data = 8'hC0;
    css = 1'b1;
    repeat (6) @(negedge clk);
    s_rdy = n_rdy;
    xfer(8'hA5, 8, 8'hFF, mi);
    check("post_rst_rdy", n_rdy - s_rdy, 1);
    check("post_rst_dat", dat_i, 8'hA5);
    check("post_rst_tx", mi, 8'hC0);
    css = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
